// File: rtl/muldiv_hilo_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_hilo_unit_if
// Request/response bundle between the core control unit and the
// multiply/divide HI/LO unit.
//
//   start  request, only looked at while busy is low
//   op     00 MUL, 01 DIV, 10 MTHI, 11 MTLO
//   sign   1 = two's complement MUL/DIV, 0 = unsigned
//   srcA   multiplicand / dividend / MTHI-MTLO data
//   srcB   multiplier / divisor
//   busy   MUL/DIV in progress (control unit stalls the PC on it)
//   done   one-cycle pulse, HI/LO carry the new result in that cycle
//   hi     MUL upper product half / DIV remainder
//   lo     MUL lower product half / DIV quotient
//
// master = control unit side, slave = the multiply/divide unit.
// ---------------------------------------------------------------------------
interface muldiv_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic             sign;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, sign, srcA, srcB,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, sign, srcA, srcB,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// ---------------------------------------------------------------------------
// muldiv_hilo_unit
// Multi-cycle multiply/divide unit that owns the HI/LO register pair.
// Iterative shift-add multiply and restoring divide, signed or unsigned.
// MTHI/MTLO write HI/LO directly in one cycle.
//
// Ports
//   clk_i   rising-edge clock
//   rst_i   synchronous, active-high reset
//   bus     muldiv_hilo_unit_if.slave (start/op/sign/srcA/srcB in,
//           busy/done/hi/lo out, all outputs registered)
//
// Parameters
//   WIDTH   operand, HI and LO width (>= 4, even)
//   CNT_W   iteration counter width, 2**CNT_W > WIDTH
//
// Configuration macro
//   FAST_MUL_EN  when defined, MUL uses a single combinational multiplier and
//                finishes one edge after acceptance; DIV stays iterative.
//
// Timing (iterative): accept at E0, WIDTH iterations on E1..E(WIDTH),
// sign fix and HI/LO write on E(WIDTH+1) together with the done pulse.
// ---------------------------------------------------------------------------
module muldiv_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    muldiv_hilo_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    // Working registers.  For MUL accHi/accLo hold the running product with
    // the multiplier being shifted out of accLo; for DIV accHi is the partial
    // remainder and accLo shifts the dividend out while the quotient shifts in.
    logic [WIDTH-1:0] accHi_q;
    logic [WIDTH-1:0] accLo_q;
    logic [WIDTH-1:0] opB_q;
    logic             isDiv_q;
    logic             negRes_q;
    logic             negRem_q;
    logic             divZero_q;

    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;

    logic [WIDTH:0]   mulSum;
    logic [WIDTH-1:0] mulHi_d;
    logic [WIDTH-1:0] mulLo_d;
    logic [WIDTH:0]   divShift;
    logic             divFits;
    logic [WIDTH-1:0] divHi_d;
    logic [WIDTH-1:0] divLo_d;

    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quoFix;
    logic [WIDTH-1:0]   remFix;

`ifdef FAST_MUL_EN
    logic [2*WIDTH-1:0] fastProd;
`endif

    // Operand magnitudes; negating MIN yields MIN, which read as unsigned is
    // exactly |MIN|, so no extra bit is needed.
    always_comb begin
        aNeg = bus.sign & bus.srcA[WIDTH-1];
        bNeg = bus.sign & bus.srcB[WIDTH-1];
        aMag = aNeg ? -bus.srcA : bus.srcA;
        bMag = bNeg ? -bus.srcB : bus.srcB;
    end

`ifdef FAST_MUL_EN
    // Single-cycle unsigned product of the magnitudes, sign fixed in FIX.
    always_comb begin
        fastProd = {{WIDTH{1'b0}}, aMag} * {{WIDTH{1'b0}}, bMag};
    end
`endif

    // One multiply step: add the multiplicand when the multiplier LSB is set,
    // then shift the whole {carry, accHi, accLo} right by one.
    always_comb begin
        mulSum  = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opB_q} : '0);
        mulHi_d = mulSum[WIDTH:1];
        mulLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
    end

    // One restoring divide step: bring down the next dividend bit and subtract
    // the divisor when it fits.  The remainder always stays below the divisor,
    // so after a successful subtract the result fits in WIDTH bits.  A zero
    // divisor always "fits", giving an all-ones quotient and rem = dividend.
    always_comb begin
        divShift = {accHi_q, accLo_q[WIDTH-1]};
        divFits  = (divShift >= {1'b0, opB_q});
        divHi_d  = divFits ? (divShift[WIDTH-1:0] - opB_q) : divShift[WIDTH-1:0];
        divLo_d  = {accLo_q[WIDTH-2:0], divFits};
    end

    // Sign correction applied in FIX.  Product and quotient take sA^sB, the
    // remainder takes the dividend's sign.  MIN / -1 wraps naturally to MIN.
    always_comb begin
        prodFix = negRes_q ? -{accHi_q, accLo_q} : {accHi_q, accLo_q};
        quoFix  = negRes_q ? -accLo_q : accLo_q;
        remFix  = negRem_q ? -accHi_q : accHi_q;
    end

    // Main sequencer: IDLE accepts requests (MTHI/MTLO complete immediately),
    // RUN iterates WIDTH times, FIX writes HI/LO and pulses done.  Requests
    // seen outside IDLE are dropped, not queued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            accHi_q   <= '0;
            accLo_q   <= '0;
            opB_q     <= '0;
            isDiv_q   <= 1'b0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.op[1]) begin
                            if (bus.op[0]) begin
                                lo_q <= bus.srcA;
                            end else begin
                                hi_q <= bus.srcA;
                            end
                        end else begin
                            busy_q    <= 1'b1;
                            cnt_q     <= '0;
                            isDiv_q   <= bus.op[0];
                            negRes_q  <= aNeg ^ bNeg;
                            negRem_q  <= aNeg;
                            divZero_q <= bus.op[0] && (bus.srcB == '0);
                            accHi_q   <= '0;
                            state_q   <= RUN;
                            if (bus.op[0]) begin
                                accLo_q <= aMag;
                                opB_q   <= bMag;
                            end else begin
                                accLo_q <= bMag;
                                opB_q   <= aMag;
`ifdef FAST_MUL_EN
                                accHi_q <= fastProd[2*WIDTH-1:WIDTH];
                                accLo_q <= fastProd[WIDTH-1:0];
                                state_q <= FIX;
`endif
                            end
                        end
                    end
                end
                RUN: begin
                    if (isDiv_q) begin
                        accHi_q <= divHi_d;
                        accLo_q <= divLo_d;
                    end else begin
                        accHi_q <= mulHi_d;
                        accLo_q <= mulLo_d;
                    end
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (isDiv_q) begin
                        hi_q <= remFix;
                        lo_q <= divZero_q ? '1 : quoFix;
                    end else begin
                        hi_q <= prodFix[2*WIDTH-1:WIDTH];
                        lo_q <= prodFix[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_hilo_unit
// Directed bench for muldiv_hilo_unit (WIDTH=32).  Each test task drives its
// own scenario and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_muldiv_hilo_unit;

    localparam int W = 32;
`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    muldiv_hilo_unit_if #(.WIDTH(W)) bus ();

    muldiv_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Drive one request for a single accepting edge; returns #1 after it.
    task automatic applyStimulus(input logic [1:0] op, input logic sgn,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op    = op;
        bus.sign  = sgn;
        bus.srcA  = a;
        bus.srcB  = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Issue a MUL/DIV and wait (bounded) for done, measuring latency in edges
    // after acceptance and the number of cycles busy was high.
    task automatic runOp(input logic [1:0] op, input logic sgn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         output int latency, output int busyCycles);
        applyStimulus(op, sgn, a, b);
        busyCycles = bus.busy ? 1 : 0;
        latency = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                latency = i;
                break;
            end
            if (bus.busy) busyCycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        compared++; if (bus.hi !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_hi got %h want %h", bus.hi, 32'h0); end
        compared++; if (bus.lo !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_lo got %h want %h", bus.lo, 32'h0); end
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
        compared++; if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        int lat, bc;
        runOp(2'b00, 1'b1, 32'hFFFFFFFD, 32'h00000005, lat, bc);
        compared++; if (lat !== MUL_LAT) begin mismatched++; $display("[TB] FAIL mul_s_latency got %0d want %0d", lat, MUL_LAT); end
        compared++; if (bc !== MUL_LAT) begin mismatched++; $display("[TB] FAIL mul_s_busy_cycles got %0d want %0d", bc, MUL_LAT); end
        compared++; if (bus.hi !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL mul_s_hi got %h want FFFFFFFF", bus.hi); end
        compared++; if (bus.lo !== 32'hFFFFFFF1) begin mismatched++; $display("[TB] FAIL mul_s_lo got %h want FFFFFFF1", bus.lo); end
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mul_s_busy_at_done got %b want 0", bus.busy); end
        @(posedge clk);
        #1;
        compared++; if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL mul_done_pulse_width got %b want 0", bus.done); end

        runOp(2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        compared++; if (lat !== MUL_LAT) begin mismatched++; $display("[TB] FAIL mul_u_latency got %0d want %0d", lat, MUL_LAT); end
        compared++; if (bus.hi !== 32'hFFFFFFFE) begin mismatched++; $display("[TB] FAIL mul_u_hi got %h want FFFFFFFE", bus.hi); end
        compared++; if (bus.lo !== 32'h00000001) begin mismatched++; $display("[TB] FAIL mul_u_lo got %h want 00000001", bus.lo); end

        // -7 * -6 signed = 42
        runOp(2'b00, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFA, lat, bc);
        compared++; if (bus.hi !== 32'h0) begin mismatched++; $display("[TB] FAIL mul_negneg_hi got %h want 00000000", bus.hi); end
        compared++; if (bus.lo !== 32'h0000002A) begin mismatched++; $display("[TB] FAIL mul_negneg_lo got %h want 0000002A", bus.lo); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_div();
        int lat, bc;
        runOp(2'b01, 1'b1, 32'hFFFFFFF9, 32'h00000002, lat, bc);
        compared++; if (lat !== DIV_LAT) begin mismatched++; $display("[TB] FAIL div_s_latency got %0d want %0d", lat, DIV_LAT); end
        compared++; if (bus.lo !== 32'hFFFFFFFD) begin mismatched++; $display("[TB] FAIL div_s_lo got %h want FFFFFFFD", bus.lo); end
        compared++; if (bus.hi !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL div_s_hi got %h want FFFFFFFF", bus.hi); end

        runOp(2'b01, 1'b1, 32'h00000007, 32'hFFFFFFFE, lat, bc);
        compared++; if (bus.lo !== 32'hFFFFFFFD) begin mismatched++; $display("[TB] FAIL div_posneg_lo got %h want FFFFFFFD", bus.lo); end
        compared++; if (bus.hi !== 32'h00000001) begin mismatched++; $display("[TB] FAIL div_posneg_hi got %h want 00000001", bus.hi); end

        runOp(2'b01, 1'b0, 32'h0000007B, 32'h00000000, lat, bc);
        compared++; if (lat !== DIV_LAT) begin mismatched++; $display("[TB] FAIL div0_u_latency got %0d want %0d", lat, DIV_LAT); end
        compared++; if (bus.hi !== 32'h0000007B) begin mismatched++; $display("[TB] FAIL div0_u_hi got %h want 0000007B", bus.hi); end
        compared++; if (bus.lo !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL div0_u_lo got %h want FFFFFFFF", bus.lo); end

        runOp(2'b01, 1'b1, 32'hFFFFFF85, 32'h00000000, lat, bc);
        compared++; if (bus.hi !== 32'hFFFFFF85) begin mismatched++; $display("[TB] FAIL div0_s_hi got %h want FFFFFF85", bus.hi); end
        compared++; if (bus.lo !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL div0_s_lo got %h want FFFFFFFF", bus.lo); end

        runOp(2'b01, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bc);
        compared++; if (bus.lo !== 32'h80000000) begin mismatched++; $display("[TB] FAIL div_min_lo got %h want 80000000", bus.lo); end
        compared++; if (bus.hi !== 32'h00000000) begin mismatched++; $display("[TB] FAIL div_min_hi got %h want 00000000", bus.hi); end

        // Unsigned: 0x80000000 / 0xFFFFFFFF = 0 rem 0x80000000
        runOp(2'b01, 1'b0, 32'h80000000, 32'hFFFFFFFF, lat, bc);
        compared++; if (bus.lo !== 32'h00000000) begin mismatched++; $display("[TB] FAIL div_u_big_lo got %h want 00000000", bus.lo); end
        compared++; if (bus.hi !== 32'h80000000) begin mismatched++; $display("[TB] FAIL div_u_big_hi got %h want 80000000", bus.hi); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mthi_mtlo();
        int donePulses;
        applyStimulus(2'b11, 1'b0, 32'h12345678, 32'h0);
        compared++; if (bus.lo !== 32'h12345678) begin mismatched++; $display("[TB] FAIL mtlo_lo got %h want 12345678", bus.lo); end
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mtlo_busy got %b want 0", bus.busy); end
        donePulses = 0;
        applyStimulus(2'b10, 1'b0, 32'hDEADBEEF, 32'h0);
        if (bus.done) donePulses++;
        compared++; if (bus.hi !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL mthi_hi got %h want DEADBEEF", bus.hi); end
        compared++; if (bus.lo !== 32'h12345678) begin mismatched++; $display("[TB] FAIL mthi_lo_kept got %h want 12345678", bus.lo); end
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done) donePulses++;
        end
        compared++; if (donePulses !== 0) begin mismatched++; $display("[TB] FAIL mthi_done_pulses got %0d want 0", donePulses); end
    endtask

    task automatic test_ignore_while_busy();
        int donePulses;
        logic [1:0] op;
        logic [W-1:0] a, b, expHi, expLo;
`ifdef FAST_MUL_EN
        op = 2'b01; a = 32'd100; b = 32'd7; expHi = 32'd2; expLo = 32'd14;
`else
        op = 2'b00; a = 32'd7; b = 32'd6; expHi = 32'd0; expLo = 32'd42;
`endif
        donePulses = 0;
        applyStimulus(op, 1'b0, a, b);
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done) donePulses++;
        end
        applyStimulus(2'b11, 1'b0, 32'h0, 32'h0);
        if (bus.done) donePulses++;
        compared++; if (bus.lo !== 32'h12345678) begin mismatched++; $display("[TB] FAIL ignore_lo_mid got %h want 12345678", bus.lo); end
        compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("[TB] FAIL ignore_busy_mid got %b want 1", bus.busy); end
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) donePulses++;
        end
        compared++; if (donePulses !== 1) begin mismatched++; $display("[TB] FAIL ignore_done_pulses got %0d want 1", donePulses); end
        compared++; if (bus.hi !== expHi) begin mismatched++; $display("[TB] FAIL ignore_hi got %h want %h", bus.hi, expHi); end
        compared++; if (bus.lo !== expLo) begin mismatched++; $display("[TB] FAIL ignore_lo got %h want %h", bus.lo, expLo); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        runOp(2'b00, 1'b0, 32'd3, 32'd5, lat, bc);
        compared++; if (bus.lo !== 32'd15) begin mismatched++; $display("[TB] FAIL b2b_first_lo got %h want 0000000F", bus.lo); end
        // Still in the done cycle: the next request must be accepted here.
        runOp(2'b01, 1'b0, 32'd100, 32'd7, lat, bc);
        compared++; if (lat !== DIV_LAT) begin mismatched++; $display("[TB] FAIL b2b_latency got %0d want %0d", lat, DIV_LAT); end
        compared++; if (bus.lo !== 32'd14) begin mismatched++; $display("[TB] FAIL b2b_lo got %h want 0000000E", bus.lo); end
        compared++; if (bus.hi !== 32'd2) begin mismatched++; $display("[TB] FAIL b2b_hi got %h want 00000002", bus.hi); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        int lat, bc;
        applyStimulus(2'b01, 1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        compared++; if (bus.hi !== 32'h0) begin mismatched++; $display("[TB] FAIL rstmid_hi got %h want 00000000", bus.hi); end
        compared++; if (bus.lo !== 32'h0) begin mismatched++; $display("[TB] FAIL rstmid_lo got %h want 00000000", bus.lo); end
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_busy got %b want 0", bus.busy); end
        compared++; if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_done got %b want 0", bus.done); end
        rst = 1'b0;
        runOp(2'b00, 1'b0, 32'd3, 32'd4, lat, bc);
        compared++; if (lat !== MUL_LAT) begin mismatched++; $display("[TB] FAIL rstmid_mul_latency got %0d want %0d", lat, MUL_LAT); end
        compared++; if (bus.lo !== 32'h0000000C) begin mismatched++; $display("[TB] FAIL rstmid_mul_lo got %h want 0000000C", bus.lo); end
        compared++; if (bus.hi !== 32'h0) begin mismatched++; $display("[TB] FAIL rstmid_mul_hi got %h want 00000000", bus.hi); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.sign  = 1'b0;
        bus.srcA  = '0;
        bus.srcB  = '0;
        test_reset();
        test_mul();
        test_div();
        test_mthi_mtlo();
        test_ignore_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
